// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared constants for the two-port memory arbiter and its bench:
//   ADDR / WORD      - memory address and data word widths
//   OWN_*            - encodings of the response-owner register
//   PTR_*            - values of the round-robin preference pointer
//   owner_next()     - who receives the read data in the following cycle
package mem_arbiter_pkg;

    localparam int ADDR = 16;
    localparam int WORD = 32;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic PTR_I = 1'b0;
    localparam logic PTR_D = 1'b1;

    // Only granted reads produce a response; writes and idle cycles do not.
    function automatic logic [1:0] owner_next(input logic i_gnt,
                                              input logic d_gnt,
                                              input logic d_we);
        logic [1:0] own;
        if (i_gnt) begin
            own = OWN_I;
        end else if (d_gnt && !d_we) begin
            own = OWN_D;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Arbitration policy between the fetch and data requesters.
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round-robin: on a conflict the requester named by ptr wins
//               and ptr_next points at the loser; uncontested grants keep ptr.
//   undefined - fixed priority: data always wins; ptr is passed through.
// Ports:
//   i_req, d_req  in  - requests
//   ptr           in  - preferred requester on a conflict (PTR_I / PTR_D)
//   gnt           out - one-hot grant, bit 0 = fetch, bit 1 = data
//   ptr_next      out - pointer value for the next cycle
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    // Grant selection and pointer update.
    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (ptr == PTR_D) begin
                gnt      = 2'b10;
                ptr_next = PTR_I;
            end else begin
                gnt      = 2'b01;
                ptr_next = PTR_D;
            end
`else
            gnt = 2'b10;
`endif
        end else if (d_req) begin
            gnt = 2'b10;
        end else if (i_req) begin
            gnt = 2'b01;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported WORD x 2^ADDR memory between instruction fetch
// and load/store. At most one requester is granted per cycle; the granted
// command drives the memory and read data is routed back one cycle later
// to the requester that issued the read.
// Configuration macro: MEM_ARB_RR_EN (round-robin; fixed data priority
// when undefined).
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   i_req, i_addr / i_gnt             - fetch request / accept
//   i_rvalid, i_rdata                 - fetch read response
//   d_req, d_we, d_addr, d_wdata      - data request
//   d_gnt, d_rvalid, d_rdata          - data accept / read response
//   m_a, m_w, m_d / m_q               - memory command / registered read data
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [WORD-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,
    output logic [ADDR-1:0] m_a,
    output logic            m_w,
    output logic [WORD-1:0] m_d,
    input  logic [WORD-1:0] m_q
);

    logic [1:0]      gnt_s;
    logic            ptr_s;
    logic            ptr_next_s;
    logic [1:0]      owner_r;
    logic [ADDR-1:0] a_hold_r;
    logic [WORD-1:0] d_hold_r;

    mem_arb_pick u_pick (
        .i_req    (i_req),
        .d_req    (d_req),
        .ptr      (ptr_s),
        .gnt      (gnt_s),
        .ptr_next (ptr_next_s)
    );

`ifdef MEM_ARB_RR_EN
    logic ptr_r;

    // Round-robin pointer; prefers data out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= PTR_D;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    assign ptr_s = ptr_r;
`else
    logic unused_ptr_s;

    assign ptr_s        = PTR_D;
    assign unused_ptr_s = ptr_next_s;
`endif

    // Grants are suppressed while reset is asserted.
    always_comb begin
        if (rst) begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end else begin
            i_gnt = gnt_s[0];
            d_gnt = gnt_s[1];
        end
    end

    // Memory command: winner's fields, otherwise the last driven values.
    always_comb begin
        if (rst) begin
            m_a = {ADDR{1'b0}};
            m_d = {WORD{1'b0}};
        end else if (d_gnt) begin
            m_a = d_addr;
            m_d = d_wdata;
        end else if (i_gnt) begin
            m_a = i_addr;
            m_d = d_hold_r;
        end else begin
            m_a = a_hold_r;
            m_d = d_hold_r;
        end
    end

    assign m_w = d_gnt & d_we;

    // Hold registers for the idle mux select and the response owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_hold_r <= {ADDR{1'b0}};
            d_hold_r <= {WORD{1'b0}};
            owner_r  <= OWN_NONE;
        end else begin
            a_hold_r <= m_a;
            d_hold_r <= m_d;
            owner_r  <= owner_next(i_gnt, d_gnt, d_we);
        end
    end

    // A read granted just before reset must not produce a response, so the
    // owner is masked by rst as well as cleared by it.
    assign i_rvalid = (owner_r == OWN_I) & ~rst;
    assign d_rvalid = (owner_r == OWN_D) & ~rst;
    assign i_rdata  = m_q;
    assign d_rdata  = m_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with a behavioural memory, a
// reference memory image and a response scoreboard. Expectations follow
// MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic [1:0]      own;
        logic [WORD-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [ADDR-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [WORD-1:0] i_rdata;
    logic            d_req;
    logic            d_we;
    logic [ADDR-1:0] d_addr;
    logic [WORD-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [WORD-1:0] d_rdata;
    logic [ADDR-1:0] m_a;
    logic            m_w;
    logic [WORD-1:0] m_d;
    logic [WORD-1:0] m_q;

    logic [WORD-1:0] mem     [0:65535];
    logic [WORD-1:0] ref_mem [0:65535];
    exp_t            exp_q[$];
    int              tests_run = 0;
    int              tests_failed = 0;
    logic            exp_ptr_d;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_a(m_a), .m_w(m_w), .m_d(m_d), .m_q(m_q)
    );

    always #5 clk = ~clk;

    // Behavioural memory: output register holds during a write.
    always @(posedge clk) begin
        if (m_w) begin
            mem[m_a] = m_d;
        end else begin
            m_q <= mem[m_a];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic ir, input logic [ADDR-1:0] ia, input logic dr,
                       input logic dw, input logic [ADDR-1:0] da, input logic [WORD-1:0] dd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    // Both requesters active: check the winner and advance the model pointer.
    task automatic expect_conflict(input string tag);
        logic win_d;
        @(negedge clk);
`ifdef MEM_ARB_RR_EN
        win_d     = exp_ptr_d;
        exp_ptr_d = ~exp_ptr_d;
`else
        win_d     = 1'b1;
`endif
        check({tag, "_dgnt"}, 32'(d_gnt), 32'(win_d));
        check({tag, "_ignt"}, 32'(i_gnt), 32'(!win_d));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop last cycle's expected response, then push this cycle's.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            check("rst_irv", 32'(i_rvalid), 32'd0);
            check("rst_drv", 32'(d_rvalid), 32'd0);
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_irv", 32'(i_rvalid), 32'(e.own == OWN_I));
                check("rsp_drv", 32'(d_rvalid), 32'(e.own == OWN_D));
                if (e.own == OWN_I) begin
                    check("rsp_idata", i_rdata, e.data);
                end else begin
                    check("rsp_ddata", d_rdata, e.data);
                end
            end else begin
                check("idle_irv", 32'(i_rvalid), 32'd0);
                check("idle_drv", 32'(d_rvalid), 32'd0);
            end
            if (i_gnt) begin
                e.own  = OWN_I;
                e.data = ref_mem[i_addr];
                exp_q.push_back(e);
            end else if (d_gnt && d_we) begin
                ref_mem[d_addr] = d_wdata;
            end else if (d_gnt) begin
                e.own  = OWN_D;
                e.data = ref_mem[d_addr];
                exp_q.push_back(e);
            end else begin
                e.own = OWN_NONE;
            end
        end
    end

    initial begin
        for (int k = 0; k < 65536; k++) begin
            mem[k]     = 32'd0;
            ref_mem[k] = 32'd0;
        end
        for (int k = 0; k < 4; k++) begin
            mem[k]     = 32'h10 + 32'(k);
            ref_mem[k] = 32'h10 + 32'(k);
        end
        exp_ptr_d = PTR_D;

        // Reset held two cycles with both requesters active.
        rst = 1'b1;
        set(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0002, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_ignt", 32'(i_gnt), 32'd0);
            check("rst_dgnt", 32'(d_gnt), 32'd0);
            check("rst_mw", 32'(m_w), 32'd0);
            check("rst_ma", 32'(m_a), 32'd0);
            check("rst_md", m_d, 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        expect_conflict("first");

        // Fetch stream over preloaded addresses.
        for (int a = 0; a < 4; a++) begin
            set(1'b1, 16'(a), 1'b0, 1'b0, 16'h0000, 32'd0);
            @(negedge clk);
            check("fetch_ignt", 32'(i_gnt), 32'd1);
            check("fetch_dgnt", 32'(d_gnt), 32'd0);
            check("fetch_ma", 32'(m_a), 32'(a));
            @(posedge clk);
            #1;
        end

        // Write then read back the same address.
        set(1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_dgnt", 32'(d_gnt), 32'd1);
        check("wr_ignt", 32'(i_gnt), 32'd0);
        check("wr_mw", 32'(m_w), 32'd1);
        check("wr_ma", 32'(m_a), 32'h1234);
        check("wr_md", m_d, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        set(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 32'hDEADBEEF);
        @(negedge clk);
        check("rd_dgnt", 32'(d_gnt), 32'd1);
        check("rd_mw", 32'(m_w), 32'd0);
        check("rd_ma", 32'(m_a), 32'h1234);
        @(posedge clk);
        #1;
        set(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'd0);
        @(negedge clk);
        check("idle_gnt", 32'({i_gnt, d_gnt}), 32'd0);
        check("idle_mw", 32'(m_w), 32'd0);
        check("hold_ma", 32'(m_a), 32'h1234);
        check("hold_md", m_d, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Sustained conflict between two reads.
        set(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0003, 32'd0);
        for (int c = 0; c < 4; c++) begin
            expect_conflict("conf");
        end

        // Fetch read granted, then reset in the following cycle.
        set(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 32'd0);
        @(negedge clk);
        check("prerst_ignt", 32'(i_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ptr_d = PTR_D;
        @(negedge clk);
        check("midrst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'd0);
        @(negedge clk);
        check("postrst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
        @(posedge clk);
        #1;

        // Pointer returns to data after reset.
        set(1'b1, 16'h0002, 1'b1, 1'b0, 16'h1234, 32'd0);
        expect_conflict("after_rst");
        set(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
